// File: rtl/mux_pipe_stage.sv
// N-input select multiplexer feeding a registered valid/ready output stage with a
// 2-entry skid buffer; each beat carries the select used and an out-of-range flag.
module mux_pipe_stage #(
  parameter  int N      = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IN*N-1:0]   in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [N-1:0]          out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [SEL_W:0] NUM_IN_X = (SEL_W+1)'(NUM_IN);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e             state_r;
  logic [N-1:0]     main_data_r;
  logic [SEL_W-1:0] main_sel_r;
  logic             main_err_r;
  logic [N-1:0]     skid_data_r;
  logic [SEL_W-1:0] skid_sel_r;
  logic             skid_err_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [N-1:0]     pick_data_s;
  logic             pick_err_s;
  logic             accept_s;
  logic             drain_s;

  // in_ready_r is the inverse of skid occupancy; it is only gated by reset,
  // never by out_ready, so backpressure does not ripple combinationally upstream.
  assign in_ready  = in_ready_r & ~rst;
  assign accept_s  = in_valid & in_ready;
  assign drain_s   = out_valid_r & out_ready;

  assign out_data  = main_data_r;
  assign out_sel   = main_sel_r;
  assign out_err   = main_err_r;
  assign out_valid = out_valid_r;

  // Select the addressed input; out-of-range selects contribute nothing and raise err.
  always_comb begin
    pick_data_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      pick_data_s = pick_data_s | (in_data[k*N +: N] & {N{sel == SEL_W'(k)}});
    end
    pick_err_s = ({1'b0, sel} >= NUM_IN_X);
  end

  // Occupancy state machine moving beats through main and skid registers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      main_data_r <= '0;
      main_sel_r  <= '0;
      main_err_r  <= 1'b0;
      skid_data_r <= '0;
      skid_sel_r  <= '0;
      skid_err_r  <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_data_r <= pick_data_s;
            main_sel_r  <= sel;
            main_err_r  <= pick_err_s;
            out_valid_r <= 1'b1;
            state_r     <= ONE;
          end
        end
        ONE: begin
          case ({accept_s, drain_s})
            2'b11: begin
              main_data_r <= pick_data_s;
              main_sel_r  <= sel;
              main_err_r  <= pick_err_s;
            end
            2'b10: begin
              skid_data_r <= pick_data_s;
              skid_sel_r  <= sel;
              skid_err_r  <= pick_err_s;
              in_ready_r  <= 1'b0;
              state_r     <= TWO;
            end
            2'b01: begin
              out_valid_r <= 1'b0;
              state_r     <= EMPTY;
            end
            default: begin
              state_r <= ONE;
            end
          endcase
        end
        TWO: begin
          // The skid beat is older than anything upstream, so it refills main first.
          if (drain_s) begin
            main_data_r <= skid_data_r;
            main_sel_r  <= skid_sel_r;
            main_err_r  <= skid_err_r;
            in_ready_r  <= 1'b1;
            state_r     <= ONE;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Drives a 4-input and a 3-input instance with shared stimulus and checks both against
// a queue-based reference of accepted beats.
module tb_mux_pipe_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready4, out_valid4, out_err4;
  logic [31:0]  out_data4;
  logic [1:0]   out_sel4;
  logic         in_ready3, out_valid3, out_err3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_pipe_stage #(.N(32), .NUM_IN(4)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .flush(flush), .out_data(out_data4), .out_sel(out_sel4),
    .out_err(out_err4), .out_valid(out_valid4), .out_ready(out_ready)
  );

  mux_pipe_stage #(.N(32), .NUM_IN(3)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data[95:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_sel(out_sel3),
    .out_err(out_err3), .out_valid(out_valid3), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [31:0] d4;
    logic        e4;
    logic [31:0] d3;
    logic        e3;
    logic [1:0]  s;
  } exp_t;

  exp_t q[$];
  logic armed    = 1'b0;
  logic zero_exp = 1'b0;
  logic last_acc = 1'b0;
  int   n_acc    = 0;

  function automatic exp_t ref_beat(logic [127:0] din, logic [1:0] s);
    exp_t e;
    int   si;
    si   = int'(s);
    e.s  = s;
    e.e4 = (si >= 4);
    e.d4 = (si < 4) ? 32'(din >> (32 * si)) : 32'd0;
    e.e3 = (si >= 3);
    e.d3 = (si < 3) ? 32'(din >> (32 * si)) : 32'd0;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the stage holds at most two beats in arrival order.
  always @(posedge clk) begin
    int   sz;
    logic acc, drn;
    sz       = q.size();
    last_acc = 1'b0;
    if (rst) armed = 1'b1;
    if (rst || flush) begin
      q.delete();
      zero_exp = 1'b1;
    end else begin
      acc = in_valid && (sz < 2);
      drn = (sz > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_beat(in_data, sel));
        zero_exp = 1'b0;
        last_acc = 1'b1;
        n_acc++;
      end
    end
  end

  logic        prev_hold = 1'b0;
  logic [31:0] prev_d4, prev_d3;

  // Monitor: compare presented outputs against the oldest outstanding beat.
  always @(negedge clk) begin
    logic exp_rdy, exp_vld;
    if (armed) begin
      exp_rdy = !rst && (q.size() < 2);
      exp_vld = (q.size() > 0);
      chk("in_ready4", 32'(in_ready4), 32'(exp_rdy));
      chk("in_ready3", 32'(in_ready3), 32'(exp_rdy));
      chk("out_valid4", 32'(out_valid4), 32'(exp_vld));
      chk("out_valid3", 32'(out_valid3), 32'(exp_vld));
      if (exp_vld) begin
        chk("data4", out_data4, q[0].d4);
        chk("sel4", 32'(out_sel4), 32'(q[0].s));
        chk("err4", 32'(out_err4), 32'(q[0].e4));
        chk("data3", out_data3, q[0].d3);
        chk("sel3", 32'(out_sel3), 32'(q[0].s));
        chk("err3", 32'(out_err3), 32'(q[0].e3));
      end else if (zero_exp) begin
        chk("zero_data4", out_data4, 32'd0);
        chk("zero_sel4", 32'(out_sel4), 32'd0);
        chk("zero_err4", 32'(out_err4), 32'd0);
        chk("zero_data3", out_data3, 32'd0);
        chk("zero_err3", 32'(out_err3), 32'd0);
      end
      if (prev_hold) begin
        chk("stable4", out_data4, prev_d4);
        chk("stable3", out_data3, prev_d3);
      end
      prev_hold = out_valid4 && !out_ready && !rst && !flush;
      prev_d4   = out_data4;
      prev_d3   = out_data3;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = 2'd0; in_data = '0;
    tick(); tick();
    rst = 1'b0;

    // streaming at full rate
    in_data = {32'h33, 32'h22, 32'h11, 32'h00};
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    repeat (6) tick();
    in_valid = 1'b0;
    tick(); tick();

    // backpressure: A, B fill main and skid, C waits upstream
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    tick();
    sel = 2'd3;
    tick();
    sel = 2'd0;
    repeat (3) tick();
    chk("c_held", 32'(last_acc), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("c_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    repeat (4) tick();

    // out-of-range select then in-range
    in_valid = 1'b1; sel = 2'd3;
    tick();
    sel = 2'd1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // flush while full with a simultaneous input beat
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd2;
    tick();
    flush = 1'b1; sel = 2'd1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // reset while full, then one beat with 1-cycle latency
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; sel = 2'd2; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // randomised valid/ready with occasional flush
    n_acc = 0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      tick();
      cyc++;
    end
    chk("random_beats", 32'(n_acc >= 1000), 32'd1);

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
